// File: rtl/pw_encoder_if.sv
// Producer-side value channel of the pulse-width encoder.
// valid/ready: a value moves on a rising aclk edge where in_valid && in_ready;
// the producer holds in_value stable while in_valid is high, and in_ready comes
// from a register only, so it never depends on in_valid in the same cycle.
interface pw_encoder_if #(
  parameter int VAL_W = 5
);
  logic             in_valid;
  logic [VAL_W-1:0] in_value;
  logic             in_ready;

  modport master (output in_valid, output in_value, input in_ready);
  modport slave  (input in_valid, input in_value, output in_ready);
endinterface

// File: rtl/pw_encoder.sv
// Binary-to-pulse-width encoder: double-buffers onset phases and emits one
// PULSE_WIDTH pulse per gamma cycle, aligned to the shared grst strobe.
module pw_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic       aclk,
  input  logic       rst_n,
  input  logic       grst,
  pw_encoder_if.slave in_bus,
  output logic       y,
  output logic       gamma_start,
  output logic       underrun,
  output logic       state_dbg
);

  localparam int PH_W = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int CW   = VAL_W + 1;
  localparam logic [VAL_W-1:0] INF  = VAL_W'(GAMMA_CYCLE_WIDTH);
  localparam logic [PH_W-1:0]  LAST = PH_W'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [CW-1:0]    PW_C = CW'(PULSE_WIDTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mode_t;

  mode_t            mode, mode_next;
  logic [PH_W-1:0]  phase, phase_next;
  logic [VAL_W-1:0] active, active_next;
  logic [VAL_W-1:0] pending, pending_next;
  logic             pending_full, pending_full_next;
  logic             boundary, xfer, y_next;
  logic [CW-1:0]    phase_ext, active_ext;
  logic [VAL_W-1:0] in_value;

  assign in_value        = in_bus.in_value;
  assign in_bus.in_ready = !pending_full;
  assign state_dbg       = (mode == RUN);

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) mode <= IDLE;
    else        mode <= mode_next;
  end

  always_comb begin
    mode_next         = mode;
    phase_next        = '0;
    active_next       = active;
    pending_next      = pending;
    pending_full_next = pending_full;
    boundary          = grst || (mode == RUN && phase == LAST);
    xfer              = in_bus.in_valid && !pending_full;

    if (mode == RUN) phase_next = phase + 1'b1;

    // The boundary sees the old pending state; a same-edge transfer only refills pending.
    if (boundary) begin
      mode_next         = RUN;
      phase_next        = '0;
      pending_full_next = 1'b0;
      active_next       = pending_full ? pending : INF;
    end

    if (xfer) begin
      pending_next      = in_value;
      pending_full_next = 1'b1;
    end

    // Extra bit keeps active+PULSE_WIDTH from wrapping; infinity never matches
    // because phase stays below GAMMA_CYCLE_WIDTH.
    phase_ext  = {{(CW - PH_W){1'b0}}, phase_next};
    active_ext = {1'b0, active_next};
    y_next     = (mode_next == RUN) && (phase_ext >= active_ext) &&
                 (phase_ext < active_ext + PW_C);
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= '0;
      active       <= INF;
      pending      <= '0;
      pending_full <= 1'b0;
      y            <= 1'b0;
      gamma_start  <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      phase        <= phase_next;
      active       <= active_next;
      pending      <= pending_next;
      pending_full <= pending_full_next;
      y            <= y_next;
      gamma_start  <= boundary;
      underrun     <= boundary && !pending_full;
    end
  end

endmodule

// File: tb/tb_pw_encoder.sv
// Bench for pw_encoder: directed scenarios with literal pulse masks, then
// randomized traffic, all checked every cycle against a queue-based model.
module tb_pw_encoder;
  localparam int G  = 16;
  localparam int PW = 8;
  localparam int VW = $clog2(G) + 1;

  logic aclk = 1'b0;
  logic rst_n, grst;
  logic y, gamma_start, underrun, state_dbg;

  pw_encoder_if #(.VAL_W(VW)) bus ();

  pw_encoder #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .VAL_W(VW)) dut (
    .aclk(aclk), .rst_n(rst_n), .grst(grst), .in_bus(bus.slave),
    .y(y), .gamma_start(gamma_start), .underrun(underrun), .state_dbg(state_dbg)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: gamma cycle as an integer phase, pending buffer as a queue.
  int  m_phase;
  int  m_active;
  bit  m_run;
  int  pend_q[$];
  bit  e_y, e_gs, e_un;

  always @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_phase = 0; m_active = G;
      pend_q.delete();
      e_y = 0; e_gs = 0; e_un = 0;
    end else begin
      bit take, bnd, had;
      take = (bus.in_valid === 1'b1) && (pend_q.size() == 0);
      bnd  = (grst === 1'b1) || (m_run && m_phase == G - 1);
      had  = pend_q.size() > 0;
      e_gs = bnd;
      e_un = bnd && !had;
      if (bnd) begin
        m_run = 1; m_phase = 0;
        m_active = had ? pend_q.pop_front() : G;
      end else if (m_run) begin
        m_phase++;
      end
      if (take) pend_q.push_back(int'(bus.in_value));
      e_y = m_run && (m_active < G) && (m_phase >= m_active) && (m_phase < m_active + PW);
    end
  end

  always @(negedge aclk) begin
    if (rst_n === 1'b1) begin
      chk("y", y, e_y);
      chk("gamma_start", gamma_start, e_gs);
      chk("underrun", underrun, e_un);
      chk("in_ready", bus.in_ready, pend_q.size() == 0);
      chk("state", state_dbg, m_run);
    end
  end

  task automatic wait_gs(input string name);
    int n = 0;
    while (gamma_start !== 1'b1 && n < 64) begin
      @(negedge aclk);
      n++;
    end
    chk({name, "_gs_timeout"}, n < 64, 1);
  endtask

  task automatic capture(input string name, input logic [15:0] exp_mask);
    logic [15:0] m;
    wait_gs(name);
    for (int i = 0; i < 16; i++) begin
      m[i] = y;
      @(negedge aclk);
    end
    chk(name, m, exp_mask);
  endtask

  task automatic send(input int v);
    int n = 0;
    @(negedge aclk);
    bus.in_valid = 1'b1;
    bus.in_value = VW'(v);
    while (bus.in_ready !== 1'b1 && n < 64) begin
      @(negedge aclk);
      n++;
    end
    chk("send_accept", n < 64, 1);
    @(negedge aclk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_grst();
    @(negedge aclk);
    grst = 1'b1;
    @(negedge aclk);
    grst = 1'b0;
  endtask

  task automatic idle_no_gs(input string name);
    int gsn = 0;
    repeat (20) begin
      @(negedge aclk);
      if (gamma_start === 1'b1) gsn++;
    end
    chk(name, gsn, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    grst  = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_y", y, 0);
    chk("rst_gs", gamma_start, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", bus.in_ready, 1);
    repeat (3) @(negedge aclk);
    rst_n = 1'b1;
    idle_no_gs("idle_no_gs");

    // Basic onset 2
    send(2);
    pulse_grst();
    chk("basic_ready", bus.in_ready, 1);
    capture("basic", 16'h03FC);

    // Clip at cycle end, then infinity
    send(12);
    pulse_grst();
    fork
      capture("clip", 16'hF000);
      begin
        repeat (3) @(negedge aclk);
        send(16);
      end
    join
    chk("clip_next_y", y, 0);
    chk("inf_underrun", underrun, 0);
    capture("inf", 16'h0000);
    chk("after_inf_underrun", underrun, 1);

    // Back-to-back and starvation
    send(3);
    pulse_grst();
    fork
      capture("b2b_first", 16'h07F8);
      begin
        repeat (4) @(negedge aclk);
        send(5);
        chk("b2b_ready_low", bus.in_ready, 0);
      end
    join
    chk("b2b_wrap_underrun", underrun, 0);
    capture("b2b_second", 16'h1FE0);
    chk("b2b_starve_underrun", underrun, 1);
    capture("b2b_starved", 16'h0000);

    // Mid-cycle grst with value 0 pending
    send(4);
    wait_gs("mid_wait");
    send(0);
    repeat (3) @(negedge aclk);
    @(negedge aclk);
    chk("mid_y_before", y, 1);
    grst = 1'b1;
    @(negedge aclk);
    grst = 1'b0;
    chk("mid_gs", gamma_start, 1);
    chk("mid_y_after", y, 1);
    capture("mid_zero", 16'h00FF);

    // Transfer landing on the wrap edge with pending empty
    repeat (15) @(negedge aclk);
    bus.in_valid = 1'b1;
    bus.in_value = VW'(1);
    @(negedge aclk);
    bus.in_valid = 1'b0;
    chk("same_underrun", underrun, 1);
    chk("same_gs", gamma_start, 1);
    chk("same_y", y, 0);
    chk("same_pending_full", bus.in_ready, 0);
    capture("same_inf", 16'h0000);
    capture("same_next", 16'h01FE);

    // Asynchronous reset in the middle of a pulse
    send(3);
    wait_gs("rst_wait");
    repeat (5) @(negedge aclk);
    chk("rst_pre_y", y, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", y, 0);
    chk("arst_gs", gamma_start, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_ready", bus.in_ready, 1);
    chk("arst_state", state_dbg, 0);
    @(negedge aclk);
    rst_n = 1'b1;
    idle_no_gs("arst_no_gs");

    // Randomized traffic
    repeat (3000) begin
      @(negedge aclk);
      grst         = ($urandom_range(0, 39) == 0);
      bus.in_valid = $urandom_range(0, 1) == 1;
      bus.in_value = VW'($urandom_range(0, (1 << VW) - 1));
    end
    @(negedge aclk);
    grst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (4) @(negedge aclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pw_encoder.md
# pw_encoder

Binary-to-pulse-width temporal encoder: the producer end of the pulse-width race-logic interface that the temporal operators (min, max, inhibit, ...) consume. It accepts binary values over a valid/ready handshake, double-buffers them, and drives each as one pulse inside a gamma cycle of GAMMA_CYCLE_WIDTH aclk cycles. A pulse starts at phase v and lasts PULSE_WIDTH cycles. Gamma-cycle alignment comes from the shared grst strobe, so several encoders feeding one operator stay phase-locked.

## Interface
- GAMMA_CYCLE_WIDTH, 16: aclk cycles per gamma cycle; must be at least 2.
- PULSE_WIDTH, 8: pulse length in aclk cycles; must be at least 1.
- VAL_W, $clog2(GAMMA_CYCLE_WIDTH)+1: width of in_value; it includes one extra bit so the value "never" (infinity) can be encoded.
- aclk  input  1  clock; the single clock domain; all flops use the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- grst  input  1  synchronous gamma-cycle start strobe, active-high, sampled on aclk.
- in_valid  input  1  in_value is presented.
- in_value  input  VAL_W  onset phase; any value of GAMMA_CYCLE_WIDTH or more means "no pulse" (infinity).
- in_ready  output  1  the pending buffer is empty and can accept a value.
- y  output  1  registered pulse-width coded output.
- gamma_start  output  1  one-cycle pulse during the cycle in which phase is 0.
- underrun  output  1  one-cycle pulse when a boundary occurs while the pending buffer is empty.

## Operation
- State: two modes, IDLE and RUN. Registers: phase (0..GAMMA_CYCLE_WIDTH-1), active value, pending value, and a pending_full flag.
- IDLE (entered on reset):
  - phase is held at 0 and y is 0.
  - No boundaries occur and no underrun is reported.
  - The handshake still accepts a value into pending.
- Handshake:
  - A transfer happens on an edge where in_valid && in_ready.
  - in_ready = !pending_full, taken from a register only; it never depends combinationally on in_valid.
- Boundary: an edge at which grst=1, or an edge in RUN at which phase == GAMMA_CYCLE_WIDTH-1. At a boundary:
  - phase becomes 0 and the mode becomes RUN.
  - If pending_full, active takes the pending value and pending_full is cleared.
  - Otherwise active takes infinity and underrun pulses.
- grst in the middle of a cycle (in RUN) is a full boundary that realigns immediately. The cycle that was running is truncated.
- Between boundaries in RUN, phase increments by 1 on each edge.
- Pulse rule: y is 1 in the cycle where phase = p exactly when active ≤ p < active+PULSE_WIDTH and p ≤ GAMMA_CYCLE_WIDTH-1.
  - A pulse is clipped at the gamma-cycle end; it never carries over into the next cycle.
  - An infinity value gives y=0 for the whole cycle.
- Comparisons are computed at VAL_W+1 bits so that active+PULSE_WIDTH cannot overflow.
- Simultaneous transfer and boundary: the boundary reads the old pending state.
  - If pending was empty, the active value becomes infinity, underrun pulses, and the value transferred on that same edge lands in pending.
  - That value is used at the next boundary. There is no bypass path into active.
- A transfer is impossible when pending_full, so a boundary with a full buffer never coincides with a transfer.

## Timing
- Reset (rst_n=0): asynchronous. Mode becomes IDLE, phase=0, active=infinity, pending_full=0, y=0, gamma_start=0, underrun=0, in_ready=1. This takes effect immediately, including in the middle of a pulse.
- All outputs are registered and are updated on the same edge as phase.
- After a boundary edge:
  - gamma_start=1 for exactly one cycle.
  - y = (new active == 0) in that same cycle, so a value of 0 gives zero latency from gamma_start.
- y rises on the edge at which phase becomes active. It falls on the edge at which phase becomes active+PULSE_WIDTH, or at the boundary edge, whichever comes first.
- underrun is high for exactly the cycle that follows the offending boundary edge.
- in_ready returns to 1 in the cycle after a boundary that consumed the pending value.
- Steady-state throughput: one value per gamma cycle. The producer may deliver the next value at any time within the current cycle.

## Test plan
(All scenarios use GAMMA_CYCLE_WIDTH=16 and PULSE_WIDTH=8.)
- Reset: pulse rst_n low in the middle of a pulse.
  - Expect y=0, gamma_start=0, underrun=0 and in_ready=1 without waiting for an aclk edge.
  - Expect no gamma_start until the first grst.
- Basic: in IDLE, transfer 2, then pulse grst one cycle.
  - Expect gamma_start in phase 0 and y=1 during phases 2..9 (8 cycles).
  - Expect in_ready=1 again from phase 0 onward.
- Clip and infinity: transfer 12 and issue grst.
  - Expect y=1 during phases 12..15 only (4 cycles) and y=0 at the next phase 0.
  - Next, transfer 16 before the wrap. Expect y=0 for the entire following cycle and underrun=0.
- Back-to-back and underrun: transfer 3 and issue grst. At phase 5, transfer 5 and check that in_ready goes to 0.
  - At the automatic wrap, expect a pulse at phases 5..12.
  - Supply no further value. At the next wrap expect underrun=1 for one cycle and y=0 for the whole cycle.
- Mid-cycle grst: active=4 and pending=0; assert grst at phase 6, while y=1.
  - Expect phase 0, gamma_start=1 and y=1 immediately, from value 0. y then holds for 8 cycles with no gap.
- Same-edge transfer and boundary: pending is empty and in_valid=1 with value 1 lands on the wrap edge.
  - Expect underrun=1 and y=0 for that cycle, with pending_full=1.
  - At the next wrap, expect y=1 during phases 1..8.
